// File: rtl/div_pkg.sv
// Shared definitions for the divider-result BCD converter: FSM encoding and
// the double-dabble correction threshold.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } div_state_e;

   localparam logic [3:0] ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_adj3.sv
// Combinational double-dabble digit corrector: a digit of 5 or more gets +3
// so the following left shift carries correctly into the next decade.
module bcd_adj3
   import div_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= ADJ_THRESH) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider's quotient/remainder to sign + BCD magnitude, one bit
// per cycle for both values in parallel (shift-and-add-3).
//
// state | meaning
// IDLE  | waiting for start with div_ready; outputs hold last result
// SHIFT | WIDTH shift/adjust cycles, counter counts down to terminal 1
// DONE  | publish BCD and sign outputs, pulse valid on the next edge
module div_result_bcd
   import div_pkg::*;
#(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sign,
   input  logic [WIDTH-1:0]      quotient,
   input  logic [WIDTH-1:0]      remainder,
   input  logic                  div_ready,
   input  logic                  start,
   output logic                  busy,
   output logic                  valid,
   output logic                  q_neg,
   output logic                  r_neg,
   output logic [4*DIGITS-1:0]   q_bcd,
   output logic [4*DIGITS-1:0]   r_bcd
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   div_state_e        state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  q_mag, r_mag;
   logic [BW-1:0]     q_acc, r_acc;
   logic [BW-1:0]     q_adj, r_adj;
   logic              q_neg_cap, r_neg_cap;
   logic              accept;
   logic              q_is_neg, r_is_neg;

   assign accept   = (state == IDLE) && start && div_ready;
   assign q_is_neg = sign && quotient[WIDTH-1];
   assign r_is_neg = sign && remainder[WIDTH-1];
   assign busy     = (state != IDLE);

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adj3 u_q_adj (.din(q_acc[4*g +: 4]), .dout(q_adj[4*g +: 4]));
      bcd_adj3 u_r_adj (.din(r_acc[4*g +: 4]), .dout(r_adj[4*g +: 4]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         q_mag     <= '0;
         r_mag     <= '0;
         q_acc     <= '0;
         r_acc     <= '0;
         q_neg_cap <= 1'b0;
         r_neg_cap <= 1'b0;
         q_bcd     <= '0;
         r_bcd     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         valid     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  // Most negative value negates to itself, which reads back
                  // correctly as an unsigned WIDTH-bit magnitude.
                  q_mag     <= q_is_neg ? (~quotient + WIDTH'(1))  : quotient;
                  r_mag     <= r_is_neg ? (~remainder + WIDTH'(1)) : remainder;
                  q_neg_cap <= q_is_neg;
                  r_neg_cap <= r_is_neg;
                  q_acc     <= '0;
                  r_acc     <= '0;
                  cnt       <= CW'(WIDTH);
               end
            end
            SHIFT: begin
               q_acc <= {q_adj[BW-2:0], q_mag[WIDTH-1]};
               r_acc <= {r_adj[BW-2:0], r_mag[WIDTH-1]};
               q_mag <= {q_mag[WIDTH-2:0], 1'b0};
               r_mag <= {r_mag[WIDTH-2:0], 1'b0};
               cnt   <= cnt - CW'(1);
            end
            DONE: begin
               q_bcd <= q_acc;
               r_bcd <= r_acc;
               q_neg <= q_neg_cap;
               r_neg <= r_neg_cap;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed scenarios plus random
// conversions checked against an arithmetic sign/magnitude/decimal model.
module tb_div_result_bcd;

   localparam int WIDTH  = 6;
   localparam int DIGITS = 2;
   localparam int BW     = 4 * DIGITS;

   logic             clk = 1'b0;
   logic             rst;
   logic             sign;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_ready;
   logic             start;
   logic             busy;
   logic             valid;
   logic             q_neg;
   logic             r_neg;
   logic [BW-1:0]    q_bcd;
   logic [BW-1:0]    r_bcd;

   int checks   = 0;
   int failures = 0;

   div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .sign      (sign),
      .quotient  (quotient),
      .remainder (remainder),
      .div_ready (div_ready),
      .start     (start),
      .busy      (busy),
      .valid     (valid),
      .q_neg     (q_neg),
      .r_neg     (r_neg),
      .q_bcd     (q_bcd),
      .r_bcd     (r_bcd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_neg(input logic s, input int v);
      return (s && v >= (1 << (WIDTH - 1))) ? 1 : 0;
   endfunction

   function automatic int ref_bcd(input logic s, input int v);
      int mag, res;
      mag = ref_neg(s, v) ? (1 << WIDTH) - v : v;
      res = 0;
      for (int d = 0; d < DIGITS; d++) begin
         res = res | ((mag % 10) << (4 * d));
         mag = mag / 10;
      end
      return res;
   endfunction

   // One full conversion; inputs are scrambled right after acceptance.
   task automatic convert(input string tag, input logic s, input int q, input int r,
                          input bit release_rst);
      int cycles;
      @(negedge clk);
      if (release_rst) rst = 1'b0;
      sign = s; quotient = WIDTH'(q); remainder = WIDTH'(r);
      start = 1'b1; div_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, int'(busy), 1);
      sign = 1'($urandom); quotient = WIDTH'($urandom); remainder = WIDTH'($urandom);
      cycles = 0;
      while (!valid && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk({tag, "_latency"}, cycles, WIDTH + 1);
      chk({tag, "_q_bcd"}, int'(q_bcd), ref_bcd(s, q));
      chk({tag, "_r_bcd"}, int'(r_bcd), ref_bcd(s, r));
      chk({tag, "_q_neg"}, int'(q_neg), ref_neg(s, q));
      chk({tag, "_r_neg"}, int'(r_neg), ref_neg(s, r));
      @(posedge clk); #1;
      chk({tag, "_valid_pulse"}, int'(valid), 0);
   endtask

   initial begin
      int nbusy, nvalid;
      logic [BW-1:0] cap_q, cap_r;
      logic s;
      int q, r;

      rst = 1'b1; sign = 1'b0; quotient = '0; remainder = '0;
      div_ready = 1'b0; start = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_q_bcd", int'(q_bcd), 0);
      chk("rst_r_bcd", int'(r_bcd), 0);
      chk("rst_negs", int'({q_neg, r_neg}), 0);
      repeat (2) @(posedge clk);

      // Start lands on the first edge after reset release.
      convert("unsigned", 1'b0, 63, 5, 1'b1);
      chk("unsigned_q_lit", int'(q_bcd), 'h63);
      convert("signed", 1'b1, 32, 61, 1'b0);
      chk("signed_q_lit", int'(q_bcd), 'h32);
      chk("signed_r_lit", int'(r_bcd), 'h03);

      // start without div_ready
      @(negedge clk);
      start = 1'b1; div_ready = 1'b0; quotient = 6'd9;
      nbusy = 0; nvalid = 0;
      repeat (10) begin
         @(posedge clk); #1;
         nbusy += int'(busy); nvalid += int'(valid);
      end
      start = 1'b0; div_ready = 1'b1;
      chk("noready_busy", nbusy, 0);
      chk("noready_valid", nvalid, 0);

      // second start during SHIFT is ignored
      @(negedge clk);
      sign = 1'b0; quotient = 6'd17; remainder = 6'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      quotient = 6'd50; remainder = 6'd44; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      nvalid = 0; cap_q = '0; cap_r = '0;
      repeat (16) begin
         @(posedge clk); #1;
         if (valid) begin
            nvalid++; cap_q = q_bcd; cap_r = r_bcd;
         end
      end
      chk("restart_valid_count", nvalid, 1);
      chk("restart_q_bcd", int'(cap_q), 'h17);
      chk("restart_r_bcd", int'(cap_r), 'h09);

      // reset mid-conversion
      @(negedge clk);
      quotient = 6'd55; remainder = 6'd21; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_q_bcd", int'(q_bcd), 0);
      chk("abort_r_bcd", int'(r_bcd), 0);
      chk("abort_valid", int'(valid), 0);
      @(negedge clk);
      rst = 1'b0;
      nvalid = 0; nbusy = 0;
      repeat (12) begin
         @(posedge clk); #1;
         nvalid += int'(valid); nbusy += int'(busy);
      end
      chk("abort_no_valid", nvalid, 0);
      chk("abort_no_busy", nbusy, 0);
      convert("after_abort", 1'b0, 55, 21, 1'b0);

      // output hold
      convert("hold", 1'b0, 42, 0, 1'b0);
      @(negedge clk);
      quotient = 6'd7;
      repeat (10) @(posedge clk);
      #1;
      chk("hold_q_bcd", int'(q_bcd), 'h42);

      convert("zero", 1'b1, 0, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         q = int'($urandom_range(0, (1 << WIDTH) - 1));
         r = int'($urandom_range(0, (1 << WIDTH) - 1));
         convert("random", s, q, r, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving the operand width; it SHALL equal the upstream divider's width.
REQ-002 SHALL have parameter DIGITS, default 2, giving the BCD digits per result; 10^DIGITS SHALL exceed 2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port sign, input, 1 bit: 1 means quotient and remainder are two's-complement signed.
REQ-006 SHALL have port quotient, input, WIDTH bits: divider quotient.
REQ-007 SHALL have port remainder, input, WIDTH bits: divider remainder.
REQ-008 SHALL have port div_ready, input, 1 bit: divider idle, so its results are stable.
REQ-009 SHALL have port start, input, 1 bit: request conversion of the current divider result.
REQ-010 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse when new BCD outputs are available.
REQ-012 SHALL have port q_neg, output, 1 bit: quotient negative.
REQ-013 SHALL have port r_neg, output, 1 bit: remainder negative.
REQ-014 SHALL have port q_bcd, output, 4*DIGITS bits: quotient magnitude in BCD, digit 0 in bits [3:0].
REQ-015 SHALL have port r_bcd, output, 4*DIGITS bits: remainder magnitude in BCD, digit 0 in bits [3:0].

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL accept a conversion only in IDLE, on a clock edge where start=1 and div_ready=1.
- On acceptance: capture magnitudes and sign flags, clear the BCD accumulators, load the bit counter with WIDTH, and go to SHIFT.
REQ-018 SHALL compute the magnitude as the two's complement of the value when sign=1 and the value's MSB=1, and as the raw value otherwise.
- Magnitude is WIDTH bits unsigned; the most negative value (e.g. -32) converts to magnitude 32.
REQ-019 SHALL set q_neg or r_neg to 1 only when sign=1 and the corresponding MSB=1.
REQ-020 SHALL convert both values in parallel in SHIFT, one bit per cycle, MSB first.
- Per digit: add 3 to every digit that is 5 or more, then shift the magnitude MSB into digit 0 bit 0.
- Carries propagate digit to digit.
REQ-021 SHALL decrement the bit counter each SHIFT cycle and go to DONE after exactly WIDTH SHIFT cycles.
REQ-022 SHALL, in DONE, update q_bcd, r_bcd, q_neg and r_neg together, pulse valid for one cycle, and return to IDLE the next cycle.
REQ-023 SHALL have a latency of WIDTH+1 cycles from the acceptance edge to the edge that asserts valid.
REQ-024 SHALL hold busy=1 in SHIFT and DONE, and busy=0 in IDLE.
REQ-025 SHALL ignore start while busy=1, and SHALL ignore start when div_ready=0.
REQ-026 SHALL hold all BCD and sign outputs at their last converted values until the next DONE.
- Input changes after acceptance SHALL have no effect.
REQ-027 SHALL sample the inputs only at acceptance.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, counter 0, busy=0, valid=0, q_neg=0, r_neg=0, q_bcd=0 and r_bcd=0, independent of clk.
REQ-029 SHALL abort any conversion in progress when rst is asserted mid-conversion; no valid SHALL follow.
REQ-030 SHALL accept start on the first clock edge after rst deasserts if start and div_ready are high.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE/SHIFT/DONE) and the add-3 threshold constant (5) in a shared package div_pkg.
REQ-032 SHALL contain one sub-module, bcd_adj3: a combinational 4-bit digit corrector (input 5 or more becomes input+3).
- It SHALL be instantiated DIGITS times per result.

Verification
REQ-033 SHALL cover unsigned conversion.
- WIDTH=6, sign=0, quotient=63, remainder=5, start with div_ready=1.
- Response: valid after 7 cycles; q_bcd=0x63, r_bcd=0x05, q_neg=0, r_neg=0.
REQ-034 SHALL cover signed conversion.
- sign=1, quotient=6'b100000 (-32), remainder=6'b111101 (-3).
- Response: q_bcd=0x32, q_neg=1, r_bcd=0x03, r_neg=1.
REQ-035 SHALL cover the gating rules.
- start with div_ready=0: response is no busy and no valid.
- start pulsed again during SHIFT: response is exactly one valid with the first-captured result.
REQ-036 SHALL cover reset mid-conversion.
- Assert rst 3 cycles after acceptance.
- Response: busy=0 and outputs zero immediately (asynchronously); no valid pulse; next start converts normally.
REQ-037 SHALL cover output hold.
- After a conversion of 42/0, change quotient to 7 without start.
- Response: q_bcd stays 0x42.
REQ-038 SHALL cover the zero case.
- quotient=0, remainder=0, sign=1.
- Response: q_bcd=0x00, r_bcd=0x00, q_neg=0, r_neg=0.
